// File: rtl/video_timing_gen_if.sv
// Output bundle of the video timing generator. The generator drives every
// signal through the master modport; sinks (pixel source, TMDS encoder,
// checkers) observe through the slave modport.
//
// Handshake: there is no valid/ready pair on this bundle. All signals are
// registered in the pixel clock domain and describe the current output cycle.
// They change only on a clock edge where the generator's enable is high, and
// a sink must treat them as valid on every clock edge.
interface video_timing_gen_if #(
  parameter int CntWidth = 12
);
  logic                hsync_o;
  logic                vsync_o;
  logic                vde_o;
  logic [CntWidth-1:0] x_o;
  logic [CntWidth-1:0] y_o;
  logic                sof_o;
  logic                eol_o;
  // Debug view of the horizontal/vertical phase decoded from the counters.
  // Encoding: 0=ACTIVE, 1=FRONT, 2=SYNC, 3=BACK. It leads the registered
  // outputs by one cycle.
  logic [1:0]          h_phase_o;
  logic [1:0]          v_phase_o;

  modport master (
    output hsync_o, vsync_o, vde_o, x_o, y_o, sof_o, eol_o,
    output h_phase_o, v_phase_o
  );

  modport slave (
    input hsync_o, vsync_o, vde_o, x_o, y_o, sof_o, eol_o,
    input h_phase_o, v_phase_o
  );
endinterface

// File: rtl/video_timing_gen.sv
// Parametrised video timing generator. A horizontal and a vertical counter
// walk the raster; the phase of each axis (active, front porch, sync, back
// porch) comes from compares against the counters. The decode is registered,
// so every output lags the counters by exactly one enabled cycle.
module video_timing_gen #(
  parameter int   HActive     = 640,
  parameter int   HFrontPorch = 16,
  parameter int   HSyncWidth  = 96,
  parameter int   HBackPorch  = 48,
  parameter int   VActive     = 480,
  parameter int   VFrontPorch = 10,
  parameter int   VSyncWidth  = 2,
  parameter int   VBackPorch  = 33,
  parameter logic HSyncPol    = 1'b0,
  parameter logic VSyncPol    = 1'b0,
  parameter int   CntWidth    = 12
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      en_i,
  video_timing_gen_if.master        timing_o
);

  localparam int HTotal = HActive + HFrontPorch + HSyncWidth + HBackPorch;
  localparam int VTotal = VActive + VFrontPorch + VSyncWidth + VBackPorch;

  // Reject degenerate timings and counters too narrow for the raster.
  if (HActive == 0 || HFrontPorch == 0 || HSyncWidth == 0 || HBackPorch == 0 ||
      VActive == 0 || VFrontPorch == 0 || VSyncWidth == 0 || VBackPorch == 0 ||
      CntWidth == 0) begin : g_zero_param
    $error("video_timing_gen: every timing parameter and CntWidth must be nonzero");
  end

  if ((longint'(HTotal) - 1) >= (longint'(1) << CntWidth) ||
      (longint'(VTotal) - 1) >= (longint'(1) << CntWidth)) begin : g_cnt_width
    $error("video_timing_gen: HTotal-1 or VTotal-1 does not fit in CntWidth bits");
  end

  // Counter boundaries, sized to the counters.
  localparam logic [CntWidth-1:0] HLast    = CntWidth'(HTotal - 1);
  localparam logic [CntWidth-1:0] HActEnd  = CntWidth'(HActive);
  localparam logic [CntWidth-1:0] HSyncBeg = CntWidth'(HActive + HFrontPorch);
  localparam logic [CntWidth-1:0] HSyncEnd = CntWidth'(HActive + HFrontPorch + HSyncWidth);
  localparam logic [CntWidth-1:0] VLast    = CntWidth'(VTotal - 1);
  localparam logic [CntWidth-1:0] VActEnd  = CntWidth'(VActive);
  localparam logic [CntWidth-1:0] VSyncBeg = CntWidth'(VActive + VFrontPorch);
  localparam logic [CntWidth-1:0] VSyncEnd = CntWidth'(VActive + VFrontPorch + VSyncWidth);

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_e;

  logic [CntWidth-1:0] h_q, h_d;
  logic [CntWidth-1:0] v_q, v_d;
  phase_e              h_phase, v_phase;

  logic                hsync_q, hsync_d;
  logic                vsync_q, vsync_d;
  logic                vde_q, vde_d;
  logic [CntWidth-1:0] x_q, x_d;
  logic [CntWidth-1:0] y_q, y_d;
  logic                sof_q, sof_d;
  logic                eol_q, eol_d;

  // Horizontal phase of the current counter value.
  always_comb begin
    h_phase = PH_BACK;
    if (h_q < HActEnd) begin
      h_phase = PH_ACTIVE;
    end else if (h_q < HSyncBeg) begin
      h_phase = PH_FRONT;
    end else if (h_q < HSyncEnd) begin
      h_phase = PH_SYNC;
    end
  end

  // Vertical phase of the current line.
  always_comb begin
    v_phase = PH_BACK;
    if (v_q < VActEnd) begin
      v_phase = PH_ACTIVE;
    end else if (v_q < VSyncBeg) begin
      v_phase = PH_FRONT;
    end else if (v_q < VSyncEnd) begin
      v_phase = PH_SYNC;
    end
  end

  // Next counter values and next registered decode; everything holds when
  // the enable is low so strobes are neither repeated nor lost.
  always_comb begin
    h_d     = h_q;
    v_d     = v_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    vde_d   = vde_q;
    x_d     = x_q;
    y_d     = y_q;
    sof_d   = sof_q;
    eol_d   = eol_q;
    if (en_i) begin
      if (h_q == HLast) begin
        h_d = '0;
        if (v_q == VLast) begin
          v_d = '0;
        end else begin
          v_d = v_q + 1'b1;
        end
      end else begin
        h_d = h_q + 1'b1;
      end
      // Sync is asserted at the polarity level, idle at its inverse.
      hsync_d = (h_phase == PH_SYNC) ? HSyncPol : ~HSyncPol;
      vsync_d = (v_phase == PH_SYNC) ? VSyncPol : ~VSyncPol;
      vde_d   = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
      x_d     = h_q;
      y_d     = v_q;
      sof_d   = (h_q == '0) && (v_q == '0);
      eol_d   = (h_q == HLast);
    end
  end

  // Counter and output registers with asynchronous reset to the idle raster.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_q     <= '0;
      v_q     <= '0;
      hsync_q <= ~HSyncPol;
      vsync_q <= ~VSyncPol;
      vde_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      vde_q   <= vde_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
    end
  end

  assign timing_o.hsync_o   = hsync_q;
  assign timing_o.vsync_o   = vsync_q;
  assign timing_o.vde_o     = vde_q;
  assign timing_o.x_o       = x_q;
  assign timing_o.y_o       = y_q;
  assign timing_o.sof_o     = sof_q;
  assign timing_o.eol_o     = eol_q;
  assign timing_o.h_phase_o = h_phase;
  assign timing_o.v_phase_o = v_phase;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a small raster: H=4/1/2/1 (HTotal=8),
// V=3/1/1/1 (VTotal=6), CntWidth=4. Instance A uses active-high syncs,
// instance B active-low; both share clock, reset and enable.
module tb_video_timing_gen;

  localparam int W = 13;  // {hsync, vsync, vde, x[3:0], y[3:0], sof, eol}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;

  always #5 clk = ~clk;

  video_timing_gen_if #(.CntWidth(4)) vid_a ();
  video_timing_gen_if #(.CntWidth(4)) vid_b ();

  video_timing_gen #(
    .HActive(4), .HFrontPorch(1), .HSyncWidth(2), .HBackPorch(1),
    .VActive(3), .VFrontPorch(1), .VSyncWidth(1), .VBackPorch(1),
    .HSyncPol(1'b1), .VSyncPol(1'b1), .CntWidth(4)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .timing_o(vid_a)
  );

  video_timing_gen #(
    .HActive(4), .HFrontPorch(1), .HSyncWidth(2), .HBackPorch(1),
    .VActive(3), .VFrontPorch(1), .VSyncWidth(1), .VBackPorch(1),
    .HSyncPol(1'b0), .VSyncPol(1'b0), .CntWidth(4)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .timing_o(vid_b)
  );

  logic [W-1:0] got_a, got_b;
  assign got_a = {vid_a.hsync_o, vid_a.vsync_o, vid_a.vde_o, vid_a.x_o, vid_a.y_o,
                  vid_a.sof_o, vid_a.eol_o};
  assign got_b = {vid_b.hsync_o, vid_b.vsync_o, vid_b.vde_o, vid_b.x_o, vid_b.y_o,
                  vid_b.sof_o, vid_b.eol_o};

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_a_q[$];
  logic [W-1:0] exp_b_q[$];
  logic [W-1:0] last_a, last_b;
  int mh, mv;
  int checks = 0;
  int errors = 0;
  int clk_cnt = 0;
  int last_sof_clk = -1;
  int sof_period = 0;
  logic sof_rise = 1'b0;
  logic prev_sof = 1'b0;

  // Expected output word for raster position (h,v) and sync polarity.
  function automatic logic [W-1:0] model_pack(input int h, input int v, input logic pol);
    logic hs, vs, de, so, eo;
    de = (h < 4) && (v < 3);
    hs = (h == 5 || h == 6) ? pol : ~pol;
    vs = (v == 4) ? pol : ~pol;
    so = (h == 0) && (v == 0);
    eo = (h == 7);
    return {hs, vs, de, 4'(h), 4'(v), so, eo};
  endfunction

  function automatic logic [W-1:0] reset_pack(input logic pol);
    return {~pol, ~pol, 11'b0};
  endfunction

  task automatic model_reset();
    mh = 0;
    mv = 0;
    last_a = reset_pack(1'b1);
    last_b = reset_pack(1'b0);
    exp_a_q.delete();
    exp_b_q.delete();
    prev_sof = 1'b0;
    last_sof_clk = -1;
  endtask

  // ---------------- driver ----------------
  // One clock cycle: drive enable, push expectations, compare after the edge.
  task automatic step(input logic e);
    logic [W-1:0] want_a, want_b;
    @(negedge clk);
    en = e;
    if (e) begin
      last_a = model_pack(mh, mv, 1'b1);
      last_b = model_pack(mh, mv, 1'b0);
      mh = mh + 1;
      if (mh == 8) begin
        mh = 0;
        mv = (mv == 5) ? 0 : mv + 1;
      end
    end
    exp_a_q.push_back(last_a);
    exp_b_q.push_back(last_b);
    @(posedge clk);
    #1;
    clk_cnt++;
    want_a = exp_a_q.pop_front();
    want_b = exp_b_q.pop_front();
    checks++;
    if (got_a !== want_a) begin
      errors++;
      $display("FAIL sb_a clk=%0d got=%h exp=%h", clk_cnt, got_a, want_a);
    end
    checks++;
    if (got_b !== want_b) begin
      errors++;
      $display("FAIL sb_b clk=%0d got=%h exp=%h", clk_cnt, got_b, want_b);
    end
    sof_rise = vid_a.sof_o && !prev_sof;
    if (sof_rise) begin
      sof_period = (last_sof_clk < 0) ? 0 : clk_cnt - last_sof_clk;
      last_sof_clk = clk_cnt;
    end
    prev_sof = vid_a.sof_o;
  endtask

  // Hold reset for two edges with enable high, then release mid-cycle.
  task automatic do_reset();
    en = 1'b1;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    en = 1'b1;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (got_a !== 13'h0000) begin
      errors++;
      $display("FAIL reset_a got=%h exp=%h", got_a, 13'h0000);
    end
    checks++;
    if (vid_b.hsync_o !== 1'b1 || vid_b.vsync_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_b_sync got=%b%b exp=11", vid_b.hsync_o, vid_b.vsync_o);
    end
    #1;
    rst_n = 1'b1;
    step(1'b1);
    checks++;
    if (vid_a.vde_o !== 1'b1 || vid_a.sof_o !== 1'b1 || vid_a.x_o !== 4'd0) begin
      errors++;
      $display("FAIL first_pixel got vde=%b sof=%b x=%0d exp vde=1 sof=1 x=0",
               vid_a.vde_o, vid_a.sof_o, vid_a.x_o);
    end
  endtask

  // After a reset release, eight enabled cycles form the first line.
  task automatic check_first_line(input string tag);
    logic [7:0] vde_v, hs_v, eol_v;
    vde_v = '0; hs_v = '0; eol_v = '0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1);
      vde_v = {vde_v[6:0], vid_a.vde_o};
      hs_v  = {hs_v[6:0], vid_a.hsync_o};
      eol_v = {eol_v[6:0], vid_a.eol_o};
      checks++;
      if (vid_a.x_o !== 4'(i) || vid_a.y_o !== 4'd0) begin
        errors++;
        $display("FAIL %s_xy i=%0d got x=%0d y=%0d exp x=%0d y=0",
                 tag, i, vid_a.x_o, vid_a.y_o, i);
      end
    end
    checks++;
    if (vde_v !== 8'b11110000) begin
      errors++;
      $display("FAIL %s_vde got=%b exp=11110000", tag, vde_v);
    end
    checks++;
    if (hs_v !== 8'b00000110) begin
      errors++;
      $display("FAIL %s_hsync got=%b exp=00000110", tag, hs_v);
    end
    checks++;
    if (eol_v !== 8'b00000001) begin
      errors++;
      $display("FAIL %s_eol got=%b exp=00000001", tag, eol_v);
    end
  endtask

  task automatic test_first_line();
    do_reset();
    check_first_line("first_line");
  endtask

  task automatic test_full_frame();
    int vde_cnt, vs_cnt, vs_runs, sof_cnt, periods;
    logic prev_vs;
    vde_cnt = 0; vs_cnt = 0; vs_runs = 0; sof_cnt = 0; periods = 0;
    prev_vs = 1'b0;
    for (int i = 0; i < 48; i++) begin
      step(1'b1);
      if (vid_a.vde_o) vde_cnt++;
      if (vid_a.sof_o) sof_cnt++;
      if (vid_a.vsync_o) begin
        vs_cnt++;
        if (!prev_vs) vs_runs++;
        checks++;
        if (vid_a.y_o !== 4'd4) begin
          errors++;
          $display("FAIL frame_vsync_line got y=%0d exp y=4", vid_a.y_o);
        end
      end
      prev_vs = vid_a.vsync_o;
    end
    checks++;
    if (vde_cnt != 12) begin
      errors++;
      $display("FAIL frame_vde_count got=%0d exp=12", vde_cnt);
    end
    checks++;
    if (vs_cnt != 8 || vs_runs != 1) begin
      errors++;
      $display("FAIL frame_vsync got cnt=%0d runs=%0d exp cnt=8 runs=1", vs_cnt, vs_runs);
    end
    checks++;
    if (sof_cnt != 1) begin
      errors++;
      $display("FAIL frame_sof_count got=%0d exp=1", sof_cnt);
    end
    for (int i = 0; i < 96; i++) begin
      step(1'b1);
      if (sof_rise && sof_period != 0) begin
        periods++;
        checks++;
        if (sof_period != 48) begin
          errors++;
          $display("FAIL frame_sof_period got=%0d exp=48", sof_period);
        end
      end
    end
    checks++;
    if (periods < 1) begin
      errors++;
      $display("FAIL frame_sof_seen got=%0d exp>=1", periods);
    end
  endtask

  task automatic test_en_gap();
    int budget;
    logic found;
    found = 1'b0;
    budget = 0;
    while (!found && budget < 60) begin
      step(1'b1);
      budget++;
      found = (vid_a.x_o == 4'd2) && (vid_a.y_o == 4'd1);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL gap_locate got=timeout exp=x2y1");
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0);
      checks++;
      if (vid_a.x_o !== 4'd2 || vid_a.y_o !== 4'd1 || vid_a.vde_o !== 1'b1 ||
          vid_a.eol_o !== 1'b0) begin
        errors++;
        $display("FAIL gap_frozen i=%0d got x=%0d y=%0d vde=%b exp x=2 y=1 vde=1",
                 i, vid_a.x_o, vid_a.y_o, vid_a.vde_o);
      end
    end
    step(1'b1);
    checks++;
    if (vid_a.x_o !== 4'd3 || vid_a.y_o !== 4'd1) begin
      errors++;
      $display("FAIL gap_resume got x=%0d y=%0d exp x=3 y=1", vid_a.x_o, vid_a.y_o);
    end
    found = 1'b0;
    budget = 0;
    while (!found && budget < 60) begin
      step(1'b1);
      budget++;
      found = sof_rise;
    end
    checks++;
    if (!found || sof_period != 53) begin
      errors++;
      $display("FAIL gap_sof_period got=%0d found=%b exp=53", sof_period, found);
    end
  endtask

  task automatic test_polarity();
    int hs_low;
    hs_low = 0;
    for (int i = 0; i < 48; i++) begin
      step(1'b1);
      if (!vid_b.hsync_o) hs_low++;
      checks++;
      if (vid_b.hsync_o !== !(vid_b.x_o == 4'd5 || vid_b.x_o == 4'd6) ||
          vid_b.vsync_o !== !(vid_b.y_o == 4'd4)) begin
        errors++;
        $display("FAIL pol_b x=%0d y=%0d got hs=%b vs=%b", vid_b.x_o, vid_b.y_o,
                 vid_b.hsync_o, vid_b.vsync_o);
      end
    end
    checks++;
    if (hs_low != 12) begin
      errors++;
      $display("FAIL pol_hs_low_count got=%0d exp=12", hs_low);
    end
  endtask

  task automatic test_mid_reset();
    int budget;
    logic found;
    found = 1'b0;
    budget = 0;
    while (!found && budget < 60) begin
      step(1'b1);
      budget++;
      found = (vid_a.x_o == 4'd3) && (vid_a.y_o == 4'd2);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL mid_locate got=timeout exp=x3y2");
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (got_a !== 13'h0000) begin
      errors++;
      $display("FAIL mid_async_a got=%h exp=%h", got_a, 13'h0000);
    end
    checks++;
    if (got_b !== reset_pack(1'b0)) begin
      errors++;
      $display("FAIL mid_async_b got=%h exp=%h", got_b, reset_pack(1'b0));
    end
    do_reset();
    check_first_line("mid_reset");
  endtask

  // ---------------- main sequence ----------------
  initial begin
    model_reset();
    test_reset();
    test_first_line();
    test_full_frame();
    test_en_gap();
    test_polarity();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised video timing generator for the HDMI/VGA output path. It produces hsync, vsync and data-enable with independent front porch, sync width, back porch and sync polarity per axis, plus pixel coordinates and start-of-frame/end-of-line strobes. It sits between the pixel clock domain and the pixel source and TMDS encoder, and replaces the fixed-blanking sync generator used in earlier exercises. All outputs are registered and the block is synthesizable.

## Interface
- HActive, 640, active pixels per line
- HFrontPorch, 16, cycles from end of active to hsync start
- HSyncWidth, 96, hsync length in cycles
- HBackPorch, 48, cycles from hsync end to next line
- VActive, 480, active lines per frame
- VFrontPorch, 10, lines from end of active to vsync start
- VSyncWidth, 2, vsync length in lines
- VBackPorch, 33, lines from vsync end to next frame
- HSyncPol, 1'b0, hsync_o level while asserted (idle level is the inverse)
- VSyncPol, 1'b0, vsync_o level while asserted
- CntWidth, 12, width of x_o/y_o and the internal counters
- clk_i  input  1  pixel clock
- rst_ni  input  1  reset; asynchronous, active-low
- en_i  input  1  advance enable; low freezes counters and outputs
- hsync_o  output  1  horizontal sync, polarity set by HSyncPol
- vsync_o  output  1  vertical sync, polarity set by VSyncPol
- vde_o  output  1  video data enable (active region)
- x_o  output  CntWidth  horizontal counter of the current output cycle
- y_o  output  CntWidth  vertical counter of the current output cycle
- sof_o  output  1  one-cycle strobe at pixel (0,0)
- eol_o  output  1  one-cycle strobe at the last cycle of every line

## Operation
- HTotal = HActive+HFrontPorch+HSyncWidth+HBackPorch. VTotal is defined the same way from the V parameters.
- Elaboration $error if any parameter is 0, or if HTotal-1 or VTotal-1 does not fit in CntWidth bits.
- Counters h_q (0..HTotal-1) and v_q (0..VTotal-1) advance only when en_i=1.
  - h_q increments every enabled cycle.
  - At h_q==HTotal-1, h_q wraps to 0 and v_q increments.
  - When v_q==VTotal-1 at that same wrap, v_q also wraps to 0.
- The decode of (h_q,v_q) is registered into the outputs on every enabled cycle:
  - vde = (h<HActive) && (v<VActive).
  - hsync asserted for h in [HActive+HFrontPorch, HActive+HFrontPorch+HSyncWidth), on every line including vertical blanking.
  - vsync asserted for entire lines v in [VActive+VFrontPorch, VActive+VFrontPorch+VSyncWidth), from h=0 through h=HTotal-1.
  - x_o=h and y_o=v, raw counter values, also valid during blanking.
  - sof = (h==0 && v==0); eol = (h==HTotal-1).
- Phases: ACTIVE, FRONT, SYNC, BACK on each axis, derived from counter compares. No separate state register is required.
- en_i=0: counters and every output register hold their values. No strobe is repeated or lost; a strobe held high simply remains high until the next enabled edge.

## Timing
- Reset values (asserted asynchronously, effective immediately):
  - h_q=0, v_q=0.
  - hsync_o=~HSyncPol, vsync_o=~VSyncPol.
  - vde_o=0, x_o=0, y_o=0, sof_o=0, eol_o=0.
- Outputs lag the counters by one cycle. The first enabled edge after reset presents pixel (0,0): vde_o=1, sof_o=1, x_o=0, y_o=0.
- Frame period is HTotal*VTotal enabled cycles. With defaults, HTotal=800, VTotal=525, and the frame period is 420000.
- Reset mid-frame: all outputs take their reset values asynchronously. After release, the sequence restarts at (0,0) on the first enabled edge.
- Last line wrap: at (HTotal-1, VTotal-1), eol_o is asserted and the next enabled cycle asserts sof_o. Both strobes are never high in the same cycle unless HTotal=1, which the parameter check excludes.

## Test plan
Small configuration for all scenarios: H=4/1/2/1 (HTotal=8), V=3/1/1/1 (VTotal=6), HSyncPol=VSyncPol=1, CntWidth=4.
- Reset with en_i=1: check hsync_o=0, vsync_o=0, vde_o=0, x/y=0. On the first edge after release, check vde_o=1, sof_o=1, x_o=0.
- First 8 enabled output cycles: vde_o=11110000, hsync_o=00000110, eol_o=00000001, x_o=0..7, y_o=0.
- Full frame (48 cycles): vde_o high for exactly 12 cycles. vsync_o high for exactly 8 consecutive cycles with y_o=4. sof_o pulses recur every 48 cycles.
- Drop en_i for 5 cycles at x_o=2, y_o=1: all outputs frozen during the gap. Sequence resumes at x_o=3, and the sof_o period becomes 53 cycles.
- HSyncPol=0, VSyncPol=0: reset hsync_o=vsync_o=1. hsync_o is low exactly at x_o=5..6, and vsync_o is low for all of line 4.
- Assert rst_ni mid-line at x_o=3, y_o=2: outputs take reset values with no clock edge. After release, the output stream equals the first scenario.
